// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the master and the matching slave.
package spi_pkg;

  localparam int WORD_W = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RECV  = 3'd4,
    ST_END   = 3'd5
  } state_t;

endpackage

// File: rtl/spi_master.sv
// SPI master: sends one 10-bit command word per frame and, for rd-data
// frames, receives a byte on MISO after RD_LAT idle cycles.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [WORD_W-1:0] req_word,
  output logic              req_ready,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [3:0] SHIFT_LAST = 4'(WORD_W - 1);
  localparam logic [3:0] WAIT_RD    = 4'(RD_LAT - 1);
  localparam logic [3:0] RECV_LAST  = 4'(DATA_W - 1);

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] shift_reg;
  logic [1:0]        cmd_reg;
  logic [3:0]        cnt_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;
  logic              ss_n_reg;
  logic              mosi_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_valid) state_next = ST_CMD;
      ST_CMD:   state_next = ST_SHIFT;
      ST_SHIFT: if (cnt_reg == 4'd0) state_next = ST_WAIT;
      ST_WAIT:  if (cnt_reg == 4'd0)
                  state_next = (cmd_reg == CMD_RD_DATA) ? ST_RECV : ST_END;
      ST_RECV:  if (cnt_reg == 4'd0) state_next = ST_END;
      ST_END:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // SS_n and MOSI are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      cmd_reg      <= CMD_WR_ADDR;
      cnt_reg      <= 4'd0;
      rx_reg       <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      ss_n_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ss_n_reg     <= (state_next == ST_IDLE) || (state_next == ST_END);
      mosi_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            shift_reg <= req_word;
            cmd_reg   <= req_word[WORD_W-1 -: 2];
            mosi_reg  <= req_word[WORD_W-1];
          end
        end
        ST_CMD: begin
          mosi_reg  <= shift_reg[WORD_W-1];
          shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
          cnt_reg   <= SHIFT_LAST;
        end
        ST_SHIFT: begin
          if (cnt_reg != 4'd0) begin
            mosi_reg  <= shift_reg[WORD_W-1];
            shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
            cnt_reg   <= cnt_reg - 4'd1;
          end else begin
            cnt_reg <= (cmd_reg == CMD_RD_DATA) ? WAIT_RD : 4'd0;
          end
        end
        ST_WAIT: begin
          if (cnt_reg != 4'd0)
            cnt_reg <= cnt_reg - 4'd1;
          else if (cmd_reg == CMD_RD_DATA)
            cnt_reg <= RECV_LAST;
        end
        ST_RECV: begin
          // rd_data only updates once the whole byte is in.
          rx_reg <= {rx_reg[DATA_W-2:0], MISO};
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            rd_data_reg  <= {rx_reg[DATA_W-2:0], MISO};
            rd_valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign SS_n      = ss_n_reg;
  assign MOSI      = mosi_reg;

endmodule

// File: tb/tb_spi_master.sv
// Randomised scoreboard bench for spi_master with a slave+RAM model on the bus.
module tb_spi_master;
  import spi_pkg::*;

  localparam int LAT  = 3;
  localparam int LAT5 = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [9:0] req_word = '0;
  logic       req_ready, busy, rd_valid, ss_n, mosi;
  logic       miso = 1'b0;
  logic [7:0] rd_data;

  logic       req_valid5 = 1'b0;
  logic [9:0] req_word5 = '0;
  logic       req_ready5, busy5, rd_valid5, ss_n5, mosi5;
  logic       miso5 = 1'b0;
  logic [7:0] rd_data5;

  always #5 clk = ~clk;

  spi_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_word(req_word),
    .req_ready(req_ready), .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
    .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
  );

  spi_master #(.RD_LAT(LAT5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid5), .req_word(req_word5),
    .req_ready(req_ready5), .busy(busy5), .rd_data(rd_data5), .rd_valid(rd_valid5),
    .SS_n(ss_n5), .MOSI(mosi5), .MISO(miso5)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: frame shape and RAM effect of each accepted word.
  typedef struct {
    logic [9:0] word;
    int         len;
    bit         has_rd;
    logic [7:0] rd;
    bit         b2b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] init_mem[256];
  logic [7:0] m_mem[256];
  logic [7:0] s_mem[256];
  logic [7:0] m_addr = '0;
  logic [7:0] s_addr = '0;
  logic [7:0] last_rd = '0;

  task automatic model_push(input logic [9:0] w, input bit b2b);
    exp_t e;
    e.word   = w;
    e.b2b    = b2b;
    e.has_rd = 1'b0;
    e.len    = 12;
    case (w[9:8])
      2'b00: m_addr = w[7:0];
      2'b01: m_mem[m_addr] = w[7:0];
      2'b10: m_addr = w[7:0];
      default: begin
        e.has_rd = 1'b1;
        e.len    = 11 + LAT + 8;
        last_rd  = m_mem[m_addr];
      end
    endcase
    e.rd = last_rd;
    exp_q.push_back(e);
  endtask

  // Slave + RAM: decodes the word from MOSI, answers rd-data from its RAM,
  // and drives noise on MISO at every other time.
  int         s_idx = 0;
  logic [9:0] s_word = '0;
  logic [7:0] s_byte;
  always @(negedge clk) begin
    if (ss_n) begin
      s_idx = 0;
      miso  = 1'($urandom);
    end else begin
      if (s_idx >= 1 && s_idx <= 10) s_word = {s_word[8:0], mosi};
      if (s_idx == 10) begin
        case (s_word[9:8])
          2'b00:   s_addr = s_word[7:0];
          2'b01:   s_mem[s_addr] = s_word[7:0];
          2'b10:   s_addr = s_word[7:0];
          default: ;
        endcase
      end
      s_byte = s_mem[s_addr];
      if (s_word[9:8] == 2'b11 && s_idx >= 11 + LAT && s_idx < 19 + LAT)
        miso = s_byte[7 - (s_idx - 11 - LAT)];
      else
        miso = 1'($urandom);
      s_idx++;
    end
  end

  // MISO source for the RD_LAT=5 instance: 8'hC3 after five idle cycles.
  int         s5_idx = 0;
  logic [7:0] pat5 = 8'hC3;
  always @(negedge clk) begin
    if (ss_n5) begin
      s5_idx = 0;
      miso5  = 1'($urandom);
    end else begin
      if (s5_idx >= 11 + LAT5 && s5_idx < 19 + LAT5)
        miso5 = pat5[7 - (s5_idx - 11 - LAT5)];
      else
        miso5 = 1'($urandom);
      s5_idx++;
    end
  end

  // Monitor: collects each SS_n-low frame and compares with the queue head.
  bit          mon_en = 1'b0;
  bit          in_frame = 1'b0;
  int          flen = 0;
  int          gap = 100;
  logic [31:0] fmosi = '0;
  bit          busy_bad = 1'b0;
  exp_t        cur;
  logic [31:0] em;
  always @(negedge clk) begin
    if (!mon_en) begin
      in_frame = 1'b0;
      gap      = 100;
      busy_bad = 1'b0;
    end else begin
      if (busy === req_ready || (!ss_n && !busy)) busy_bad = 1'b1;
      if (!ss_n) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          flen     = 0;
          fmosi    = '0;
          if (exp_q.size() > 0 && exp_q[0].b2b) chk("b2b_gap", gap, 2);
          else chk("min_gap", 32'(gap >= 2), 1);
        end
        if (flen < 32) fmosi[flen] = mosi;
        flen++;
        if (rd_valid) chk("rd_valid_in_frame", rd_valid, 0);
      end else if (in_frame) begin
        in_frame = 1'b0;
        gap      = 1;
        chk("frame_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          em  = '0;
          em[0] = cur.word[9];
          for (int k = 0; k < 10; k++) em[1 + k] = cur.word[9 - k];
          chk($sformatf("len_%03h", cur.word), flen, cur.len);
          chk($sformatf("mosi_%03h", cur.word), fmosi, em);
          chk($sformatf("rd_valid_%03h", cur.word), rd_valid, cur.has_rd);
          chk($sformatf("rd_data_%03h", cur.word), rd_data, cur.rd);
          chk("busy_vs_ready", busy_bad, 0);
          busy_bad = 1'b0;
        end
      end else begin
        gap++;
        if (rd_valid) chk("rd_valid_stray", rd_valid, 0);
      end
    end
  end

  task automatic send(input logic [9:0] w, input bit b2b, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_word  = w;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", req_ready, 1);
    @(posedge clk);
    if (push) model_push(w, b2b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         len5;
    bit         got;
    bit         hold;
    logic [7:0] rdv;
    logic [9:0] w;

    for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
    init_mem[8'h3C] = 8'h5A;
    m_mem = init_mem;
    s_mem = init_mem;

    repeat (3) @(negedge clk);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // RD_LAT=5 instance: one rd-data frame against the C3 source.
    @(negedge clk);
    req_valid5 = 1'b1;
    req_word5  = 10'h3A7;
    @(posedge clk);
    #1 req_valid5 = 1'b0;
    n = 0; len5 = 0; got = 1'b0; rdv = '0;
    while (n < 60 && !got) begin
      @(negedge clk);
      if (!ss_n5) len5++;
      if (rd_valid5) begin
        got = 1'b1;
        rdv = rd_data5;
      end
      n++;
    end
    chk("lat5_rd_valid", got, 1);
    chk("lat5_rd_data", rdv, 8'hC3);
    chk("lat5_len", len5, 11 + LAT5 + 8);

    // Directed: write, full read, back-to-back, busy-ignore.
    send(10'h0A5, 1'b0, 1'b1);
    #1 req_valid = 1'b0;
    send(10'h23C, 1'b0, 1'b1);
    #1 req_valid = 1'b0;
    send(10'h300, 1'b0, 1'b1);
    #1 req_valid = 1'b0;
    send(10'h012, 1'b0, 1'b1);
    send(10'h1AB, 1'b1, 1'b1);
    #1 req_valid = 1'b0;
    send(10'h0A5, 1'b0, 1'b1);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    req_valid = 1'b1;
    req_word  = 10'h1FF;
    @(negedge clk);
    req_valid = 1'b0;

    // Random words, sometimes held back-to-back.
    hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      w = 10'($urandom);
      send(w, hold, 1'b1);
      hold = 1'($urandom);
      if (!hold) begin
        #1 req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    #1 req_valid = 1'b0;

    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", exp_q.size(), 0);

    // Reset during the 4th RECV cycle of an rd-data frame.
    send(10'h23C, 1'b0, 1'b1);
    #1 req_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    mon_en = 1'b0;
    send(10'h300, 1'b0, 1'b0);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ss_n && n < 20);
    repeat (11 + LAT + 3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ss_n", ss_n, 1);
    chk("abort_mosi", mosi, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    chk("abort_rd_valid_held", rd_valid, 0);
    rst_n = 1'b1;
    last_rd = '0;
    @(negedge clk);
    chk("abort_ready", req_ready, 1);
    chk("abort_ss_n_after", ss_n, 1);
    mon_en = 1'b1;

    send(10'h300, 1'b0, 1'b1);
    #1 req_valid = 1'b0;
    send(10'h155, 1'b0, 1'b1);
    #1 req_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
